// File: rtl/arb_pkg.sv
// Shared constants for the 8-way round-robin arbiter: state encoding and sizes.
package arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

endpackage

// File: rtl/arb_rr8_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
interface arb_rr8_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             timeout;

  // Requester side: raises requests, observes the grant.
  modport master (
    output req,
    input  grant, grant_idx, grant_valid, timeout
  );

  // Arbiter side: samples requests, drives the grant.
  modport slave (
    input  req,
    output grant, grant_idx, grant_valid, timeout
  );

endinterface

// File: rtl/onehot_dec3to8.sv
// 3-to-8 one-hot decoder, purely combinational.
module onehot_dec3to8 (
  input  logic [2:0] idx,
  output logic [7:0] onehot
);

  // Map each binary code to its single set bit.
  always_comb begin
    case (idx)
      3'b000:  onehot = 8'h01;
      3'b001:  onehot = 8'h02;
      3'b010:  onehot = 8'h04;
      3'b011:  onehot = 8'h08;
      3'b100:  onehot = 8'h10;
      3'b101:  onehot = 8'h20;
      3'b110:  onehot = 8'h40;
      3'b111:  onehot = 8'h80;
      default: onehot = 8'h00;
    endcase
  end

endmodule

// File: rtl/arb_rr8.sv
// Round-robin arbiter for eight requesters with a bounded hold time and a
// mandatory idle cycle after every grant. All outputs come from flops.
module arb_rr8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 16
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  arb_rr8_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic             state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             to_q, to_d;

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] cand;
  logic [N_REQ-1:0] dec_out;

  logic owner_req;
  logic hold_done;
  logic release_now;

  // The current owner keeps the resource while it still requests and has
  // not yet used up its hold budget.
  assign owner_req   = bus.req[idx_q];
  assign hold_done   = (cnt_q == HOLD_LAST);
  assign release_now = !owner_req || hold_done;

  // Rotating priority search: first set request at ptr, ptr+1, ... mod 8.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ptr_q + IDX_W'(k);
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  onehot_dec3to8 u_dec (
    .idx    (sel_idx),
    .onehot (dec_out)
  );

  // State, pointer, hold counter and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      to_q    <= to_d;
    end
  end

  // Next-state: leave IDLE on any request, leave GRANT on release or timeout.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      if (sel_found) state_d = ST_GRANT;
    end else begin
      if (release_now) state_d = ST_IDLE;
    end
  end

  // Next values of pointer, counter and registered outputs.
  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    to_d    = 1'b0;
    if (state_q == ST_IDLE) begin
      if (sel_found) begin
        idx_d   = sel_idx;
        grant_d = dec_out;
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        idx_d   = '0;
        grant_d = '0;
        valid_d = 1'b0;
      end
    end else begin
      if (release_now) begin
        idx_d   = '0;
        grant_d = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
        ptr_d   = idx_q + IDX_W'(1);
        // Only a forced release (owner still requesting) flags timeout.
        to_d    = owner_req;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;
  assign bus.timeout     = to_q;

endmodule

// File: tb/tb_arb_rr8.sv
// Bench for arb_rr8 with MAX_HOLD=4, checked against a behavioural owner/ptr model.
module tb_arb_rr8;

  localparam int MH = 4;

  logic clk;
  logic rst_n;
  arb_rr8_if bus ();

  arb_rr8 #(.MAX_HOLD(MH), .CNT_W(16)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  logic [2:0] dec_idx;
  logic [7:0] dec_out;
  onehot_dec3to8 u_dec (.idx(dec_idx), .onehot(dec_out));

  int n_vec = 0;
  int n_err = 0;

  // Model: who owns the resource (-1 = nobody), where the search starts,
  // how many cycles the current grant has been visible, and timeout flag.
  int m_owner;
  int m_ptr;
  int m_held;
  bit m_to;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_to    = 1'b0;
  endfunction

  function automatic void model_clock(input logic [7:0] r);
    bit found;
    m_to  = 1'b0;
    found = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        if (!found && r[(m_ptr + k) % 8]) begin
          found   = 1'b1;
          m_owner = (m_ptr + k) % 8;
          m_held  = 1;
        end
      end
    end else if (!r[m_owner] || m_held == MH) begin
      m_to    = r[m_owner];
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
      m_held  = 0;
    end else begin
      m_held++;
    end
  endfunction

  function automatic logic [12:0] model_vec();
    logic [7:0] g;
    logic [2:0] i;
    g = (m_owner >= 0) ? (8'd1 << m_owner) : 8'h00;
    i = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
    return {g, i, (m_owner >= 0), m_to};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_clock(bus.req);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.req = 8'h00;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (obs_vec() !== 13'h0)
        begin n_err++; $display("FAIL reset_outputs got=%h want=%h", obs_vec(), 13'h0); end
    end
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 8'h04;
    tick();
    n_vec++;
    if (obs_vec() !== {8'h04, 3'd2, 1'b1, 1'b0})
      begin n_err++; $display("FAIL single_req got=%h want=%h", obs_vec(), {8'h04, 3'd2, 1'b1, 1'b0}); end
    n_vec++;
    if (obs_vec() !== model_vec())
      begin n_err++; $display("FAIL single_req_model got=%h want=%h", obs_vec(), model_vec()); end
  endtask

  task automatic test_release();
    logic [12:0] want [4];
    logic [7:0]  reqs [4];
    reqs = '{8'h00, 8'h05, 8'h04, 8'h04};
    want = '{13'h0, {8'h01, 3'd0, 1'b1, 1'b0}, 13'h0, {8'h04, 3'd2, 1'b1, 1'b0}};
    for (int s = 0; s < 4; s++) begin
      bus.req = reqs[s];
      tick();
      n_vec++;
      if (obs_vec() !== want[s] || obs_vec() !== model_vec())
        begin n_err++; $display("FAIL release_step%0d got=%h want=%h model=%h", s, obs_vec(), want[s], model_vec()); end
    end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_timeout();
    bus.req = 8'h80;
    for (int c = 0; c < MH; c++) begin
      tick();
      n_vec++;
      if (obs_vec() !== {8'h80, 3'd7, 1'b1, 1'b0} || obs_vec() !== model_vec())
        begin n_err++; $display("FAIL timeout_hold%0d got=%h model=%h", c, obs_vec(), model_vec()); end
    end
    tick();
    n_vec++;
    if (obs_vec() !== {8'h00, 3'd0, 1'b0, 1'b1} || obs_vec() !== model_vec())
      begin n_err++; $display("FAIL timeout_pulse got=%h model=%h", obs_vec(), model_vec()); end
    tick();
    n_vec++;
    if (obs_vec() !== {8'h80, 3'd7, 1'b1, 1'b0} || obs_vec() !== model_vec())
      begin n_err++; $display("FAIL timeout_regrant got=%h model=%h", obs_vec(), model_vec()); end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_contention();
    logic [12:0] want;
    int ph;
    bus.req = 8'hFF;
    for (int c = 1; c <= 8 * (MH + 1) + 1; c++) begin
      tick();
      ph = (c - 1) % (MH + 1);
      if (ph < MH) want = {8'd1 << (((c - 1) / (MH + 1)) % 8), 3'(((c - 1) / (MH + 1)) % 8), 1'b1, 1'b0};
      else         want = {8'h00, 3'd0, 1'b0, 1'b1};
      n_vec++;
      if (obs_vec() !== want || obs_vec() !== model_vec())
        begin n_err++; $display("FAIL contention_c%0d got=%h want=%h model=%h", c, obs_vec(), want, model_vec()); end
      n_vec++;
      if (!$onehot0(bus.grant) || bus.grant_valid !== (|bus.grant))
        begin n_err++; $display("FAIL contention_onehot_c%0d grant=%h valid=%b", c, bus.grant, bus.grant_valid); end
    end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_mid_reset();
    bus.req = 8'h10;
    tick();
    n_vec++;
    if (obs_vec() !== {8'h10, 3'd4, 1'b1, 1'b0})
      begin n_err++; $display("FAIL midrst_pre got=%h want=%h", obs_vec(), {8'h10, 3'd4, 1'b1, 1'b0}); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (obs_vec() !== 13'h0)
      begin n_err++; $display("FAIL midrst_async got=%h want=%h", obs_vec(), 13'h0); end
    @(posedge clk);
    #3;
    rst_n   = 1'b1;
    bus.req = 8'hFF;
    tick();
    n_vec++;
    if (obs_vec() !== {8'h01, 3'd0, 1'b1, 1'b0} || obs_vec() !== model_vec())
      begin n_err++; $display("FAIL midrst_first got=%h model=%h", obs_vec(), model_vec()); end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 3);
      if (r == 0) bus.req = 8'($urandom);
      else if (r == 1 && m_owner >= 0) bus.req[m_owner] = 1'b0;
      tick();
      n_vec++;
      if (obs_vec() !== model_vec() || !$onehot0(bus.grant) || bus.grant_valid !== (|bus.grant))
        begin n_err++; $display("FAIL random_c%0d req=%h got=%h model=%h", c, bus.req, obs_vec(), model_vec()); end
    end
    bus.req = 8'h00;
  endtask

  task automatic test_decoder();
    for (int i = 0; i < 8; i++) begin
      dec_idx = 3'(i);
      #1;
      n_vec++;
      if (dec_out !== (8'd1 << i))
        begin n_err++; $display("FAIL decoder_idx%0d got=%h want=%h", i, dec_out, 8'd1 << i); end
    end
    dec_idx = 3'b111;
    #1;
    n_vec++;
    if (dec_out !== 8'h80)
      begin n_err++; $display("FAIL decoder_111 got=%h want=%h", dec_out, 8'h80); end
  endtask

  initial begin
    dec_idx = 3'd0;
    test_reset();
    test_release();
    test_timeout();
    test_contention();
    test_mid_reset();
    test_random();
    test_decoder();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
